hamming_encoder_stream: RTL

HAMMING_ENCODER_STREAM -- requirements
Module: hamming_encoder_stream

---
 rtl/hamming_encoder_stream.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hamming_encoder_stream.sv
// hamming_encoder_stream
//   Streams each accepted byte out as two SECDED(8,4) codewords: the
//   low-nibble codeword first, then the high-nibble codeword. Each codeword is
//   Hamming(7,4) plus an overall even-parity bit in cw[0].
//
//   Optional feature macro: HAMMING_ENC_ERR_INJECT_EN
//     When defined, err_inj/err_pos are sampled at input acceptance. If
//     err_inj is set, bit err_pos of the low-nibble codeword is inverted.
//     When undefined, both ports are ignored and no capture logic is built.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_data    in   [7:0] byte to encode
//   in_valid   in   in_data presented
//   in_ready   out  byte accepted when in_valid && in_ready
//   out_data   out  [7:0] registered codeword
//   out_valid  out  out_data valid
//   out_ready  in   codeword consumed when out_valid && out_ready
//   byte_count out  [COUNT_W-1:0] fully emitted bytes, wraps silently
//   err_inj    in   fault-injection enable (macro builds only)
//   err_pos    in   [2:0] bit of the low codeword to flip
module hamming_encoder_stream #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] byte_count,
  input  logic               err_inj,
  input  logic [2:0]         err_pos
);

  typedef enum logic [1:0] {S_IDLE, S_SEND_LO, S_SEND_HI} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_out_data;
  logic [3:0]           r_hi_nib;
  logic [COUNT_W-1:0]   r_count;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_lo_hs;
  logic                 w_hi_hs;
  logic [7:0]           w_lo_cw;

  function automatic logic [7:0] f_enc(input logic [3:0] d);
    logic [7:0] c;
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[4] = d[1] ^ d[2] ^ d[3];
    c[0] = ^c[7:1];
    return c;
  endfunction

`ifdef HAMMING_ENC_ERR_INJECT_EN
  // The flip is folded in at acceptance, so the injected fault is captured
  // together with the codeword itself.
  assign w_lo_cw = f_enc(in_data[3:0]) ^ (err_inj ? (8'h01 << err_pos) : 8'h00);
`else
  logic w_unused_err;
  assign w_unused_err = ^{err_inj, err_pos};
  assign w_lo_cw      = f_enc(in_data[3:0]);
`endif

  assign w_accept = in_valid && w_in_ready;
  assign w_lo_hs  = (r_state == S_SEND_LO) && out_ready;
  assign w_hi_hs  = (r_state == S_SEND_HI) && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (out_ready) w_state_nxt = S_SEND_HI;
      end
      S_SEND_HI: begin
        // A new byte may be taken in the same cycle the high codeword drains,
        // which is what gives one byte every two cycles.
        w_in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? S_SEND_LO : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset cycle: nothing may be accepted.
    if (rst) w_in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_out_data <= 8'h00;
      r_hi_nib   <= 4'h0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_out_data <= w_lo_cw;
        r_hi_nib   <= in_data[7:4];
      end else if (w_lo_hs) begin
        r_out_data <= f_enc(r_hi_nib);
      end
      if (w_hi_hs) r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready   = w_in_ready;
  assign out_data   = r_out_data;
  assign out_valid  = (r_state != S_IDLE);
  assign byte_count = r_count;

endmodule
